// File: rtl/lvl_state_array.sv
// Per-level decision state array with a backtrack-level search engine.
// Each level holds {has_bkt, dcd_bin}. A search walks down from a start
// level one entry per cycle looking for the first level that has not been
// backtracked yet. Applying the result marks that level as backtracked and
// wipes every deeper level.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | storage writable, waiting for find_start_i
// SCAN  | evaluating level scan_idx_q, storage frozen
// DONE  | one-cycle completion pulse, result registers already valid
module lvl_state_array #(
  parameter  int NUM_LVLS         = 16,
  parameter  int WIDTH_LVL        = 16,
  parameter  int WIDTH_BIN        = 10,
  localparam int WIDTH_LVL_STATES = WIDTH_BIN + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 dcd_valid_i,
  input  logic [WIDTH_LVL-1:0]                 dcd_lvl_i,
  input  logic [WIDTH_BIN-1:0]                 dcd_bin_i,
  input  logic                                 find_start_i,
  input  logic [WIDTH_LVL-1:0]                 max_lvl_i,
  output logic                                 busy_o,
  output logic                                 find_done_o,
  output logic                                 find_found_o,
  output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
  output logic [WIDTH_BIN-1:0]                 bkt_bin_o,
  input  logic                                 apply_bkt_i,
  input  logic [NUM_LVLS-1:0]                  wr_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
  output logic                                 lvl_ovf_o
);

  localparam int IDX_W = $clog2(NUM_LVLS);
  // One extra bit so level-range compares cannot wrap at NUM_LVLS = 2**WIDTH_LVL.
  localparam logic [WIDTH_LVL:0] NUM_W  = (WIDTH_LVL+1)'(NUM_LVLS);
  localparam logic [WIDTH_LVL:0] LAST_W = (WIDTH_LVL+1)'(NUM_LVLS - 1);
  localparam logic [IDX_W-1:0]   LAST_I = IDX_W'(NUM_LVLS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     scan_idx_q;
  logic                 found_q;
  logic [IDX_W-1:0]     bkt_idx_q;
  logic [WIDTH_BIN-1:0] bkt_bin_q;
  logic                 ovf_q;
  logic                 has_bkt_q [NUM_LVLS];
  logic [WIDTH_BIN-1:0] dcd_bin_q [NUM_LVLS];

  logic                 scan_ld, scan_dec, res_ld, res_found;
  logic [IDX_W-1:0]     res_idx;
  logic [WIDTH_BIN-1:0] res_bin;
  logic [IDX_W-1:0]     start_idx;
  logic                 idle, apply_en, dcd_in_range, dcd_en;
  logic [IDX_W-1:0]     dcd_idx;

  assign idle         = (state_q == S_IDLE);
  assign apply_en     = idle && apply_bkt_i && found_q;
  assign dcd_in_range = ({1'b0, dcd_lvl_i} < NUM_W);
  assign dcd_en       = idle && dcd_valid_i && dcd_in_range && (dcd_lvl_i != '0);
  assign dcd_idx      = dcd_lvl_i[IDX_W-1:0];

  // Clip the requested start level to the deepest level actually stored.
  always_comb begin
    start_idx = max_lvl_i[IDX_W-1:0];
    if ({1'b0, max_lvl_i} >= LAST_W) start_idx = LAST_I;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and scan decisions; one level examined per SCAN cycle.
  always_comb begin
    state_d   = state_q;
    scan_ld   = 1'b0;
    scan_dec  = 1'b0;
    res_ld    = 1'b0;
    res_found = 1'b0;
    res_idx   = '0;
    res_bin   = '0;
    case (state_q)
      S_IDLE: begin
        if (find_start_i) begin
          state_d = S_SCAN;
          scan_ld = 1'b1;
        end
      end
      S_SCAN: begin
        if (scan_idx_q == '0) begin
          // Root reached without a candidate: unsatisfiable.
          state_d = S_DONE;
          res_ld  = 1'b1;
        end else if (!has_bkt_q[scan_idx_q]) begin
          state_d   = S_DONE;
          res_ld    = 1'b1;
          res_found = 1'b1;
          res_idx   = scan_idx_q;
          res_bin   = dcd_bin_q[scan_idx_q];
        end else begin
          scan_dec = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scan index, search result and overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_idx_q <= '0;
      found_q    <= 1'b0;
      bkt_idx_q  <= '0;
      bkt_bin_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (scan_ld)       scan_idx_q <= start_idx;
      else if (scan_dec) scan_idx_q <= scan_idx_q - 1'b1;
      if (res_ld) begin
        found_q   <= res_found;
        bkt_idx_q <= res_idx;
        bkt_bin_q <= res_bin;
      end else if (apply_en) begin
        found_q <= 1'b0;
      end
      if (idle && dcd_valid_i && !dcd_in_range) ovf_q <= 1'b1;
    end
  end

  // Level storage; per level: direct load beats backtrack beats decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LVLS; i++) begin
        has_bkt_q[i] <= 1'b0;
        dcd_bin_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LVLS; i++) begin
        if (idle && wr_states_i[i]) begin
          has_bkt_q[i] <= lvl_states_i[i*WIDTH_LVL_STATES + WIDTH_BIN];
          dcd_bin_q[i] <= lvl_states_i[i*WIDTH_LVL_STATES +: WIDTH_BIN];
        end else if (apply_en && (IDX_W'(i) > bkt_idx_q)) begin
          has_bkt_q[i] <= 1'b0;
          dcd_bin_q[i] <= '0;
        end else if (apply_en && (IDX_W'(i) == bkt_idx_q)) begin
          has_bkt_q[i] <= 1'b1;
        end else if (dcd_en && (dcd_idx == IDX_W'(i))) begin
          has_bkt_q[i] <= 1'b0;
          dcd_bin_q[i] <= dcd_bin_i;
        end
      end
    end
  end

  // Packed combinational view of the storage.
  always_comb begin
    lvl_states_o = '0;
    for (int i = 0; i < NUM_LVLS; i++)
      lvl_states_o[i*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] = {has_bkt_q[i], dcd_bin_q[i]};
  end

  assign busy_o       = (state_q != S_IDLE);
  assign find_done_o  = (state_q == S_DONE);
  assign find_found_o = found_q;
  assign bkt_lvl_o    = WIDTH_LVL'(bkt_idx_q);
  assign bkt_bin_o    = bkt_bin_q;
  assign lvl_ovf_o    = ovf_q;

endmodule

// File: tb/tb_lvl_state_array.sv
// Directed bench for lvl_state_array with a search-result scoreboard.
module tb_lvl_state_array;

  localparam int N  = 16;
  localparam int WL = 16;
  localparam int WB = 10;
  localparam int WS = WB + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            dcd_valid_i;
  logic [WL-1:0]   dcd_lvl_i;
  logic [WB-1:0]   dcd_bin_i;
  logic            find_start_i;
  logic [WL-1:0]   max_lvl_i;
  logic            busy_o, find_done_o, find_found_o;
  logic [WL-1:0]   bkt_lvl_o;
  logic [WB-1:0]   bkt_bin_o;
  logic            apply_bkt_i;
  logic [N-1:0]    wr_states_i;
  logic [WS*N-1:0] lvl_states_i;
  logic [WS*N-1:0] lvl_states_o;
  logic            lvl_ovf_o;

  lvl_state_array #(.NUM_LVLS(N), .WIDTH_LVL(WL), .WIDTH_BIN(WB)) dut (
    .clk(clk), .rst(rst),
    .dcd_valid_i(dcd_valid_i), .dcd_lvl_i(dcd_lvl_i), .dcd_bin_i(dcd_bin_i),
    .find_start_i(find_start_i), .max_lvl_i(max_lvl_i),
    .busy_o(busy_o), .find_done_o(find_done_o), .find_found_o(find_found_o),
    .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o),
    .apply_bkt_i(apply_bkt_i), .wr_states_i(wr_states_i),
    .lvl_states_i(lvl_states_i), .lvl_states_o(lvl_states_o),
    .lvl_ovf_o(lvl_ovf_o)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct packed {
    logic          found;
    logic [WL-1:0] lvl;
    logic [WB-1:0] bin;
    int            cyc;
  } exp_t;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [WS-1:0] model [N];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WS*N-1:0] model_vec();
    logic [WS*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*WS +: WS] = model[i];
    return v;
  endfunction

  task automatic chk_states(input string nm);
    chk(nm, 256'(lvl_states_o), 256'(model_vec()));
  endtask

  // Pops one expectation per completion pulse.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && find_done_o) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: pulse at cycle %0d with no search pending", edge_cnt + 1);
        end else begin
          e = sb_q.pop_front();
          chk("done_found", 256'(find_found_o), 256'(e.found));
          chk("done_lvl",   256'(bkt_lvl_o),    256'(e.lvl));
          chk("done_bin",   256'(bkt_bin_o),    256'(e.bin));
          chk("done_cycle", 256'(edge_cnt + 1), 256'(e.cyc));
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_search(input int m, input int k, input logic found,
                              input int bin, input bit push);
    exp_t e;
    int   mc;
    mc = (m > N - 1) ? N - 1 : m;
    find_start_i = 1'b1;
    max_lvl_i    = WL'(m);
    e.found = found;
    e.lvl   = WL'(k);
    e.bin   = WB'(bin);
    e.cyc   = edge_cnt + 1 + 2 + (mc - k);
    if (push) sb_q.push_back(e);
    @(negedge clk);
    find_start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy_o; i++) @(negedge clk);
    chk("search_timeout", 256'(busy_o), 256'(0));
  endtask

  task automatic dcd(input int lvl, input int bin);
    dcd_valid_i = 1'b1;
    dcd_lvl_i   = WL'(lvl);
    dcd_bin_i   = WB'(bin);
    @(negedge clk);
    dcd_valid_i = 1'b0;
  endtask

  // Loads the levels in mask from the model.
  task automatic load(input logic [N-1:0] mask);
    wr_states_i  = mask;
    lvl_states_i = model_vec();
    @(negedge clk);
    wr_states_i = '0;
  endtask

  task automatic apply();
    apply_bkt_i = 1'b1;
    @(negedge clk);
    apply_bkt_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    dcd_valid_i = 0; dcd_lvl_i = '0; dcd_bin_i = '0;
    find_start_i = 0; max_lvl_i = '0; apply_bkt_i = 0;
    wr_states_i = '0; lvl_states_i = '0;
    for (int i = 0; i < N; i++) model[i] = '0;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy",   256'(busy_o),       256'(0));
    chk("rst_done",   256'(find_done_o),  256'(0));
    chk("rst_found",  256'(find_found_o), 256'(0));
    chk("rst_ovf",    256'(lvl_ovf_o),    256'(0));
    chk_states("rst_states");

    // Decisions at levels 1..4, then mark 3 and 4 as backtracked.
    dcd(1, 3); model[1] = 11'h003;
    dcd(2, 5); model[2] = 11'h005;
    dcd(3, 7); model[3] = 11'h007;
    dcd(4, 9); model[4] = 11'h009;
    chk_states("decisions");
    model[3] = 11'h407; model[4] = 11'h409;
    load(16'h0018);
    chk_states("load_bkt");

    // Search from 4 hits level 2; writes during the scan must be ignored.
    start_search(4, 2, 1'b1, 5, 1'b1);
    dcd_valid_i = 1'b1; dcd_lvl_i = 16'd5; dcd_bin_i = 10'd1;
    wr_states_i = 16'h0040; lvl_states_i = '1;
    @(negedge clk);
    dcd_valid_i = 1'b0; wr_states_i = '0; lvl_states_i = '0;
    wait_idle();
    chk_states("frozen_in_scan");
    repeat (2) @(negedge clk);
    chk("hold_found", 256'(find_found_o), 256'(1));
    chk("hold_lvl",   256'(bkt_lvl_o),    256'(2));
    chk("hold_bin",   256'(bkt_bin_o),    256'(5));

    // Apply: level 2 backtracked, deeper levels wiped, level 1 untouched.
    apply();
    model[2] = 11'h405;
    for (int i = 3; i < N; i++) model[i] = '0;
    chk_states("apply_result");
    chk("apply_found_clr", 256'(find_found_o), 256'(0));

    // Everything backtracked: scan runs to the root, apply is then ignored.
    model[1] = 11'h403; model[2] = 11'h405; model[3] = 11'h407; model[4] = 11'h409;
    load(16'h001E);
    start_search(4, 0, 1'b0, 0, 1'b1);
    wait_idle();
    chk("unsat_lvl", 256'(bkt_lvl_o), 256'(0));
    apply();
    chk_states("apply_ignored_unsat");

    // Oversized start level clips to the deepest level.
    for (int i = 0; i < N; i++) model[i] = WS'(i);
    load('1);
    chk_states("load_all");
    start_search(1000, 15, 1'b1, 15, 1'b1);
    wait_idle();

    // Same cycle: load of 15 beats apply at 15, decision at 3 still lands.
    wr_states_i  = 16'h8000;
    model[15]    = 11'h02A;
    lvl_states_i = model_vec();
    apply_bkt_i  = 1'b1;
    dcd_valid_i  = 1'b1; dcd_lvl_i = 16'd3; dcd_bin_i = 10'd9;
    @(negedge clk);
    wr_states_i = '0; apply_bkt_i = 1'b0; dcd_valid_i = 1'b0;
    model[3] = 11'h009;
    chk_states("prio_wr_over_apply");
    chk("prio_found_clr", 256'(find_found_o), 256'(0));

    // Apply clearing level 14 beats a decision at level 14.
    model[14] = 11'h40E; model[15] = 11'h42A;
    load(16'hC000);
    start_search(15, 13, 1'b1, 13, 1'b1);
    wait_idle();
    apply_bkt_i = 1'b1;
    dcd_valid_i = 1'b1; dcd_lvl_i = 16'd14; dcd_bin_i = 10'h33;
    @(negedge clk);
    apply_bkt_i = 1'b0; dcd_valid_i = 1'b0;
    model[13] = 11'h40D; model[14] = '0; model[15] = '0;
    chk_states("prio_apply_over_dcd");

    // Out-of-range and root decisions.
    dcd(16, 1);
    chk_states("ovf_no_write");
    chk("ovf_set", 256'(lvl_ovf_o), 256'(1));
    dcd(0, 5);
    chk_states("lvl0_ignored");
    repeat (3) @(negedge clk);
    chk("ovf_sticky", 256'(lvl_ovf_o), 256'(1));

    // Reset in the middle of a long scan.
    for (int i = 1; i < N; i++) model[i] = 11'h400 | WS'(i);
    load(16'hFFFE);
    chk("pre_rst_bkt_lvl", 256'(bkt_lvl_o), 256'(13));
    start_search(15, 0, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) model[i] = '0;
    chk("mid_rst_busy",  256'(busy_o),      256'(0));
    chk("mid_rst_done",  256'(find_done_o), 256'(0));
    chk("mid_rst_lvl",   256'(bkt_lvl_o),   256'(0));
    chk("mid_rst_bin",   256'(bkt_bin_o),   256'(0));
    chk("mid_rst_ovf",   256'(lvl_ovf_o),   256'(0));
    chk_states("mid_rst_states");
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_busy", 256'(busy_o), 256'(0));
    chk("sb_empty", 256'(sb_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
